// File: rtl/cart_arb_pkg.sv
// ============================================================================
// Module      : cart_arb_pkg
// Description : Shared types and constants for the cartridge ROM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_0 = 1'b0,
        REQ_1 = 1'b1
    } req_id_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 7;
    localparam int LAT_W      = 3;

    function automatic bit rd_lat_ok(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cart_arb_hold.sv
// ============================================================================
// Module      : cart_arb_hold
// Description : Download holding register; one-deep buffer for HPS writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cart_arb_hold #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              wr,
    input  logic              clr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    // A capture in the same cycle as a clear keeps the buffer full.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (wr) begin
            full <= 1'b1;
            addr <= wr_addr;
            data <= wr_data;
        end else if (clr) begin
            full <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cart_rom_arbiter.sv
// ============================================================================
// Module      : cart_rom_arbiter
// Description : Shares one cart ROM between two cart readers and the download
//               writer. Define CART_ARB_RR_EN for round-robin read arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cart_rom_arbiter
    import cart_arb_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [DATA_W-1:0] dl_data,
    output logic              dl_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int             RD_LAT_EFF = rd_lat_ok(RD_LAT) ? RD_LAT : RD_LAT_MAX;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT_EFF - 1);

    arb_state_t        state;
    arb_state_t        state_nx;
    req_id_t           grant;
    req_id_t           grant_nx;
    req_id_t           pick;
    logic [LAT_W-1:0]  lat_cnt;
    logic              start_wr;
    logic              start_rd;
    logic              rd_done;
    logic              hold_clr;
    logic              hold_full;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;

    cart_arb_hold #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_hold (
        .clk_sys (clk_sys),
        .reset   (reset),
        .wr      (dl_wr),
        .clr     (hold_clr),
        .wr_addr (dl_addr),
        .wr_data (dl_data),
        .full    (hold_full),
        .addr    (hold_addr),
        .data    (hold_data)
    );

    assign dl_wait = hold_full;

`ifdef CART_ARB_RR_EN
    req_id_t last_grant;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            last_grant <= REQ_1;
        end else if (start_rd) begin
            last_grant <= grant_nx;
        end
    end

    always_comb begin
        pick = req0 ? REQ_0 : REQ_1;
        if (req0 && req1) begin
            pick = (last_grant == REQ_1) ? REQ_0 : REQ_1;
        end
    end
`else
    always_comb begin
        pick = req0 ? REQ_0 : REQ_1;
    end
`endif

    // No read grant in the ack cycle: the acked requester still holds req.
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        start_wr = 1'b0;
        start_rd = 1'b0;
        rd_done  = 1'b0;
        hold_clr = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hold_full) begin
                    state_nx = ST_WRITE;
                    start_wr = 1'b1;
                end else if (!(ack0 || ack1) && (req0 || req1)) begin
                    state_nx = ST_READ;
                    start_rd = 1'b1;
                    grant_nx = pick;
                end
            end
            ST_WRITE: begin
                hold_clr = 1'b1;
                state_nx = ST_IDLE;
            end
            ST_READ: begin
                if (lat_cnt == '0) begin
                    rd_done  = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= ST_IDLE;
            grant    <= REQ_0;
            lat_cnt  <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            state  <= state_nx;
            grant  <= grant_nx;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            mem_we <= 1'b0;
            if (start_wr) begin
                mem_we   <= 1'b1;
                mem_addr <= hold_addr;
                mem_din  <= hold_data;
            end
            if (start_rd) begin
                mem_addr <= (grant_nx == REQ_1) ? addr1 : addr0;
                lat_cnt  <= LAT_LOAD;
            end else if (state == ST_READ && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            // A requester that withdrew mid-read gets neither ack nor data.
            if (rd_done) begin
                if (grant == REQ_0 && req0) begin
                    ack0   <= 1'b1;
                    rdata0 <= mem_dout;
                end
                if (grant == REQ_1 && req1) begin
                    ack1   <= 1'b1;
                    rdata1 <= mem_dout;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cart_rom_arbiter.sv
// ============================================================================
// Module      : tb_cart_rom_arbiter
// Description : Self-checking bench for cart_rom_arbiter (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cart_rom_arbiter;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 2;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              req0, req1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic              ack0, ack1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              dl_wr;
    logic [ADDR_W-1:0] dl_addr;
    logic [DATA_W-1:0] dl_data;
    logic              dl_wait;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    cart_rom_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .addr0    (addr0),
        .addr1    (addr1),
        .ack0     (ack0),
        .ack1     (ack1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .dl_wr    (dl_wr),
        .dl_addr  (dl_addr),
        .dl_data  (dl_data),
        .dl_wait  (dl_wait),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    always #5 clk_sys = ~clk_sys;

    // ROM model: word content equals low address bits; data appears RD_LAT
    // capture edges after the address was registered.
    logic [ADDR_W-1:0] hist [0:7];
    always @(posedge clk_sys) begin
        for (int i = 7; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= mem_addr;
    end
    assign mem_dout = (RD_LAT == 1) ? mem_addr[DATA_W-1:0]
                                    : hist[(RD_LAT >= 2) ? RD_LAT - 2 : 0][DATA_W-1:0];

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;
    wr_t wq[$];

    task automatic dl_issue(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        wq.push_back({a, d});
        tick();
        dl_wr = 1'b0;
    endtask

    task automatic wait_ack(input int id, input int limit, output int n);
        n = 0;
        while (!((id == 1) ? ack1 : ack0) && n < limit) begin
            tick();
            n++;
        end
    endtask

    // Every memory write must match the oldest outstanding download.
    always @(negedge clk_sys) begin
        if (!reset) begin
            if (mem_we || ack0 || ack1)
                check_eq("we_ack_excl", {31'b0, mem_we & (ack0 | ack1)}, 32'd0);
            if (mem_we) begin
                if (wq.size() == 0) begin
                    check_eq("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    check_eq("wr_addr", mem_addr, w.a);
                    check_eq("wr_data", mem_din, w.d);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    int n, n0, n1, g, seen, cyc, last, id, exp_id;

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        tick(); tick();
        check_eq("rst_ack0", ack0, 0);
        check_eq("rst_ack1", ack1, 0);
        check_eq("rst_rdata0", rdata0, 0);
        check_eq("rst_rdata1", rdata1, 0);
        check_eq("rst_dl_wait", dl_wait, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_din", mem_din, 0);
        reset = 1'b0;
        tick();

        // Uncontended read
        req0 = 1'b1; addr0 = 24'h000080;
        wait_ack(0, 20, n);
        check_eq("rd_lat", n, RD_LAT + 1);
        check_eq("rd_data", rdata0, 16'h0080);
        check_eq("rd_mem_addr", mem_addr, 24'h000080);
        req0 = 1'b0;
        tick();
        check_eq("ack_pulse", ack0, 0);
        check_eq("rd_hold", rdata0, 16'h0080);

        // Download write while idle
        dl_issue(24'h000142, 16'h80C0);
        check_eq("wr_wait_c1", dl_wait, 1);
        check_eq("wr_we_c1", mem_we, 0);
        tick();
        check_eq("wr_we_c2", mem_we, 1);
        check_eq("wr_addr_c2", mem_addr, 24'h000142);
        check_eq("wr_din_c2", mem_din, 16'h80C0);
        tick();
        check_eq("wr_wait_c3", dl_wait, 0);
        check_eq("wr_we_c3", mem_we, 0);

        // Download arrives during a read of requester 1
        req1 = 1'b1; addr1 = 24'h1234AB;
        tick();
        dl_issue(24'h3FFFFF, 16'hBEEF);
        check_eq("mid_wait", dl_wait, 1);
        wait_ack(1, 20, n);
        check_eq("mid_rd_lat", n + 2, RD_LAT + 1);
        check_eq("mid_rd_data", rdata1, 16'h34AB);
        check_eq("mid_we_in_ack", mem_we, 0);
        req1 = 1'b0;
        tick();
        check_eq("mid_we_after", mem_we, 1);
        tick(); tick();

        // Both requesters held continuously
        reset = 1'b1; tick(); reset = 1'b0; tick();
        req0 = 1'b1; addr0 = 24'h000111;
        req1 = 1'b1; addr1 = 24'h000222;
        seen = 0; cyc = 0; last = 0;
        while (seen < 4 && cyc < 100) begin
            tick();
            cyc++;
            if (ack0 || ack1) begin
                id = ack1 ? 1 : 0;
`ifdef CART_ARB_RR_EN
                exp_id = seen % 2;
`else
                exp_id = 0;
`endif
                check_eq("fair_id", id, exp_id);
                check_eq("fair_gap", cyc - last, (seen == 0) ? RD_LAT + 1 : RD_LAT + 2);
                check_eq("fair_data", (id == 1) ? rdata1 : rdata0, (id == 1) ? 16'h0222 : 16'h0111);
                last = cyc;
                seen++;
            end
        end
        check_eq("fair_cnt", seen, 4);
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick();

        // Write and read visible in the same idle cycle: write goes first
        dl_issue(24'h000500, 16'h1111);
        req0 = 1'b1; addr0 = 24'h000600;
        wait_ack(0, 30, n);
        check_eq("wr_then_rd_lat", n + 1, RD_LAT + 4);
        check_eq("wr_then_rd_data", rdata0, 16'h0600);
        req0 = 1'b0;
        tick();

        // Requester withdraws before completion
        req0 = 1'b1; addr0 = 24'h000777;
        tick();
        req0 = 1'b0;
        for (int k = 0; k < RD_LAT + 3; k++) begin
            tick();
            check_eq("drop_noack", ack0, 0);
        end
        check_eq("drop_rdata", rdata0, 16'h0600);

        // Reset in the middle of a read with a pending download
        req1 = 1'b1; addr1 = 24'h00ABCD;
        tick();
        dl_issue(24'h0F0F0F, 16'h2222);
        reset = 1'b1; req1 = 1'b0;
        tick();
        check_eq("rstmid_ack1", ack1, 0);
        check_eq("rstmid_wait", dl_wait, 0);
        check_eq("rstmid_we", mem_we, 0);
        check_eq("rstmid_rdata1", rdata1, 0);
        wq.delete();
        reset = 1'b0;
        tick();
        req1 = 1'b1; addr1 = 24'h00C0DE;
        wait_ack(1, 20, n);
        check_eq("rstmid_lat", n, RD_LAT + 1);
        check_eq("rstmid_data", rdata1, 16'hC0DE);
        req1 = 1'b0;
        tick();

        // Random traffic from both readers and the downloader
        fork
            for (int k = 0; k < 25; k++) begin
                repeat ($urandom_range(1, 3)) tick();
                addr0 = ADDR_W'($urandom);
                req0  = 1'b1;
                wait_ack(0, 200, n0);
                check_eq("rnd_to0", n0 < 200, 1);
                check_eq("rnd_data0", rdata0, addr0[DATA_W-1:0]);
                req0 = 1'b0;
            end
            for (int k = 0; k < 25; k++) begin
                repeat ($urandom_range(1, 3)) tick();
                addr1 = ADDR_W'($urandom);
                req1  = 1'b1;
                wait_ack(1, 200, n1);
                check_eq("rnd_to1", n1 < 200, 1);
                check_eq("rnd_data1", rdata1, addr1[DATA_W-1:0]);
                req1 = 1'b0;
            end
            for (int k = 0; k < 20; k++) begin
                repeat ($urandom_range(1, 8)) tick();
                g = 0;
                while (dl_wait && g < 50) begin
                    tick();
                    g++;
                end
                check_eq("rnd_dl_to", g < 50, 1);
                dl_issue(ADDR_W'($urandom), DATA_W'($urandom));
            end
        join

        repeat (RD_LAT + 6) tick();
        check_eq("wq_drain", wq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
